// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcode mnemonics, sequencer states and PC width shared by the sequencer and its bench
package alu_sequencer_pkg;
   localparam int PC_W = 10;
   // KBRN and KHALT occupy two codes the ALU leaves unused; code 15 stays unassigned
   typedef enum logic [3:0] {
      KADD, KSUB, KAND, KOR, KXOR, KLSH, KRSH, KGET,
      KSET, KGETI, KSTR, KLOA, KLUT, KBRN, KHALT
   } op_mne;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_DONE} seq_state_t;
endpackage

// File: rtl/seq_regfile.sv
// seq_regfile: 8x8 register file, two async read ports, one sync write port
//   clk, rst_n           clock and async active-low clear of all registers
//   raddr_a/b, rdata_a/b combinational read ports
//   we, waddr, wdata     write port, takes effect on the rising edge
module seq_regfile
   import alu_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] raddr_a,
   output logic [7:0] rdata_a,
   input  logic [2:0] raddr_b,
   output logic [7:0] rdata_b,
   input  logic       we,
   input  logic [2:0] waddr,
   input  logic [7:0] wdata
);
   logic [7:0] regs_q [8];
   logic [7:0] regs_d [8];
   always_comb begin
      regs_d = regs_q;
      if (we) regs_d[waddr] = wdata;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= '{default: 8'h00};
      else regs_q <= regs_d;
   end
   assign rdata_a = regs_q[raddr_a];
   assign rdata_b = regs_q[raddr_b];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute sequencer driving an external ALU, instruction ROM and data RAM
//   clk, rst_n                    clock, async active-low reset
//   start / ack                   begin program at PC 0 / program reached KHALT
//   imem_addr, imem_data          instruction ROM (1-cycle read latency)
//   alu_op, alu_a, alu_b, alu_is_branch, alu_out, alu_branch   external ALU
//   dmem_addr, dmem_wdata, dmem_we, dmem_rdata                 data RAM (1-cycle read latency)
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            ack,
   output logic [PC_W-1:0] imem_addr,
   input  logic [8:0]      imem_data,
   output logic [3:0]      alu_op,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   output logic            alu_is_branch,
   input  logic [7:0]      alu_out,
   input  logic            alu_branch,
   output logic [7:0]      dmem_addr,
   output logic [7:0]      dmem_wdata,
   output logic            dmem_we,
   input  logic [7:0]      dmem_rdata
);
   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_br;
   logic [8:0]      ir_q, ir_d;
   logic            ack_q, ack_d;
   logic [7:0]      dmem_addr_q, dmem_addr_d;
   logic [3:0]      op;
   logic [2:0]      rs, rf_waddr;
   logic [7:0]      rs_val, r0_val, imm, rf_wdata;
   logic            exec, mem, alu_grp, rf_we;
   assign op      = ir_q[8:5];
   assign rs      = ir_q[2:0];
   assign imm     = {3'b000, ir_q[4:0]};
   assign exec    = state_q == S_EXEC;
   assign mem     = state_q == S_MEM;
   assign alu_grp = op <= KRSH;
   assign pc_inc  = pc_q + PC_W'(1);
   assign pc_br   = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
   seq_regfile u_rf (
      .clk    (clk),
      .rst_n  (rst_n),
      .raddr_a(rs),
      .rdata_a(rs_val),
      .raddr_b(3'd0),
      .rdata_b(r0_val),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata)
   );
   assign alu_op        = exec ? op : 4'd0;
   assign alu_a         = !exec ? 8'h00 : (alu_grp || op == KSET || op == KBRN) ? r0_val : (op == KLOA) ? rs_val : 8'h00;
   assign alu_b         = !exec ? 8'h00 : (alu_grp || op == KGET) ? rs_val : (op == KGETI) ? imm : (op == KSTR) ? r0_val : 8'h00;
   assign alu_is_branch = exec && op == KBRN;
   assign dmem_we       = exec && op == KSTR;
   assign dmem_wdata    = dmem_we ? alu_out : 8'h00;
   // the load address is captured in EXEC so it stays on the bus through MEM
   assign dmem_addr     = exec ? ((op == KSTR) ? rs_val : (op == KLOA) ? alu_out : 8'h00) : mem ? dmem_addr_q : 8'h00;
   assign dmem_addr_d   = dmem_addr;
   assign rf_we         = (exec && (alu_grp || op == KGET || op == KGETI || op == KSET)) || mem;
   assign rf_waddr      = (exec && op == KSET) ? rs : 3'd0;
   assign rf_wdata      = mem ? dmem_rdata : alu_out;
   assign ack           = ack_q;
   assign imem_addr     = pc_q;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ack_d   = ack_q;
      case (state_q)
         S_IDLE, S_DONE: if (start) begin
            state_d = S_FETCH;
            pc_d    = '0;
            ack_d   = 1'b0;
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = imem_data;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = (op == KLOA) ? S_MEM : (op == KHALT) ? S_DONE : S_FETCH;
            ack_d   = op == KHALT;
            pc_d    = (op == KLOA || op == KHALT) ? pc_q : (op == KBRN && alu_branch) ? pc_br : pc_inc;
         end
         S_MEM: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         ack_q       <= 1'b0;
         dmem_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         ack_q       <= ack_d;
         dmem_addr_q <= dmem_addr_d;
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench with ROM/RAM/ALU environment and an instruction-level reference model
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ram_init = 1'b0;
   logic       ack, alu_is_branch, alu_branch, dmem_we;
   logic [9:0] imem_addr;
   logic [8:0] imem_data;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b, alu_out, dmem_addr, dmem_wdata, dmem_rdata;
   logic [8:0] rom [1024];
   logic [7:0] ram [256];
   logic [7:0] m_mem [256];
   logic [7:0] m_r [8];
   logic [9:0] m_pc;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ack(ack),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_is_branch(alu_is_branch),
      .alu_out(alu_out), .alu_branch(alu_branch),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
   );

   // external ALU behaviour assumed by the bench; branch is taken on a nonzero A
   function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         KADD: return a + b;
         KSUB: return a - b;
         KAND: return a & b;
         KOR:  return a | b;
         KXOR: return a ^ b;
         KLSH: return a << b[2:0];
         KRSH: return a >> b[2:0];
         KGET, KGETI, KSTR: return b;
         KSET, KLOA, KBRN: return a;
         default: return 8'h00;
      endcase
   endfunction

   assign alu_out    = alu_f(alu_op, alu_a, alu_b);
   assign alu_branch = alu_is_branch && alu_a != 8'h00;

   always @(posedge clk) begin
      imem_data  <= rom[imem_addr];
      dmem_rdata <= ram[dmem_addr];
      if (ram_init) ram <= m_mem;
      else if (dmem_we) ram[dmem_addr] <= dmem_wdata;
   end

   function automatic logic [8:0] enc(input op_mne o, input int f);
      logic [4:0] v;
      v = f[4:0];
      return {o, v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ack", ack, 0);
      chk("rst_pc", imem_addr, 0);
      chk("rst_op", alu_op, 0);
      chk("rst_a", alu_a, 0);
      chk("rst_b", alu_b, 0);
      chk("rst_br", alu_is_branch, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_daddr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      m_r = '{default: 8'h00};
      step();
      rst_n = 1'b1;
      step();
   endtask

   // executes the ROM program one instruction at a time from PC 0, checking the bus at each phase
   task automatic run_prog(input int max_n, output bit halted);
      logic [8:0] w;
      logic [3:0] op;
      logic [2:0] rs;
      logic [7:0] imm, a;
      halted = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ack_after_start", ack, 0);
      m_pc = '0;
      for (int n = 0; n < max_n && !halted; n++) begin
         w   = rom[m_pc];
         op  = w[8:5];
         rs  = w[2:0];
         imm = {3'b000, w[4:0]};
         chk("fetch_pc", imem_addr, m_pc);
         start = 1'($urandom);
         step();
         chk("decode_op_idle", alu_op, 0);
         chk("decode_we_idle", dmem_we, 0);
         start = 1'($urandom);
         step();
         chk("exec_op", alu_op, op);
         chk("exec_is_branch", alu_is_branch, op == KBRN);
         chk("exec_we", dmem_we, op == KSTR);
         if (op <= KRSH) begin
            chk("alu_a_r0", alu_a, m_r[0]);
            chk("alu_b_rs", alu_b, m_r[rs]);
            m_r[0] = alu_f(op, m_r[0], m_r[rs]);
         end else begin
            case (op)
               KGET: begin
                  chk("get_b", alu_b, m_r[rs]);
                  m_r[0] = m_r[rs];
               end
               KSET: begin
                  chk("set_a", alu_a, m_r[0]);
                  m_r[rs] = m_r[0];
               end
               KGETI: begin
                  chk("geti_b", alu_b, imm);
                  m_r[0] = imm;
               end
               KSTR: begin
                  chk("str_b", alu_b, m_r[0]);
                  chk("str_addr", dmem_addr, m_r[rs]);
                  chk("str_data", dmem_wdata, m_r[0]);
                  m_mem[m_r[rs]] = m_r[0];
               end
               KLOA: begin
                  chk("loa_a", alu_a, m_r[rs]);
                  chk("loa_addr", dmem_addr, m_r[rs]);
               end
               KBRN: chk("brn_a", alu_a, m_r[0]);
               KHALT: halted = 1'b1;
               default: ;
            endcase
         end
         start = 1'($urandom);
         step();
         if (halted) start = 1'b0;
         if (op == KLOA) begin
            a = m_r[rs];
            chk("mem_addr_held", dmem_addr, a);
            chk("mem_op_idle", alu_op, 0);
            chk("mem_we_idle", dmem_we, 0);
            m_r[0] = m_mem[a];
            start = 1'($urandom);
            step();
         end
         if (op == KBRN && m_r[0] != 8'h00) m_pc = m_pc + {{5{w[4]}}, w[4:0]};
         else if (op != KHALT) m_pc = m_pc + 10'd1;
      end
      if (halted) begin
         chk("halt_ack", ack, 1);
         step();
         step();
         chk("halt_pc_frozen", imem_addr, m_pc);
         chk("halt_ack_held", ack, 1);
      end
   endtask

   initial begin
      bit h;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
      for (int i = 0; i < 1024; i++) rom[i] = enc(KLUT, 0);
      ram_init = 1'b1;
      step();
      ram_init = 1'b0;
      do_reset();
      chk("idle_hold_ack", ack, 0);
      chk("idle_hold_pc", imem_addr, 0);
      // arithmetic, register moves, store and load
      rom[0]  = enc(KGETI, 3);  rom[1]  = enc(KSET, 1);  rom[2]  = enc(KGETI, 5);
      rom[3]  = enc(KSUB, 1);   rom[4]  = enc(KADD, 1);  rom[5]  = enc(KGETI, 16);
      rom[6]  = enc(KSET, 2);   rom[7]  = enc(KGETI, 10); rom[8] = enc(KSET, 4);
      rom[9]  = enc(KGETI, 4);  rom[10] = enc(KSET, 5);  rom[11] = enc(KGET, 4);
      rom[12] = enc(KLSH, 5);   rom[13] = enc(KSET, 4);  rom[14] = enc(KGETI, 11);
      rom[15] = enc(KOR, 4);    rom[16] = enc(KSTR, 2);  rom[17] = enc(KGETI, 0);
      rom[18] = enc(KLOA, 2);   rom[19] = enc(KSTR, 0);  rom[20] = enc(KHALT, 0);
      run_prog(60, h);
      chk("ram_store_10", ram[8'h10], 8'hAB);
      chk("ram_store_ab", ram[8'hAB], 8'hAB);
      // taken and not-taken branches in both directions
      for (int i = 0; i < 21; i++) rom[i] = enc(KLUT, 0);
      rom[0] = enc(KGETI, 1); rom[1] = enc(KBRN, 3);  rom[4] = enc(KBRN, -2);
      rom[2] = enc(KGETI, 0); rom[3] = enc(KBRN, 0);  rom[5] = enc(KGETI, 1);
      rom[6] = enc(KHALT, 0);
      run_prog(60, h);
      // PC wrap below 0 and above 1023
      rom[0] = enc(KBRN, -1); rom[1023] = enc(KGETI, 0); rom[1] = enc(KHALT, 0);
      run_prog(60, h);
      // reset during the EXEC cycle of a store aborts the write
      rom[0] = enc(KGETI, 7); rom[1] = enc(KSET, 2); rom[2] = enc(KGETI, 9); rom[3] = enc(KSTR, 2);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("abort_fetch_pc", imem_addr, 3);
      step();
      step();
      chk("abort_pre_we", dmem_we, 1);
      do_reset();
      chk("abort_no_write", ram[7], m_mem[7]);
      // every register reads back as zero after the reset
      for (int i = 0; i < 7; i++) rom[i] = enc(KGET, i + 1);
      rom[7] = enc(KADD, 0);
      rom[8] = enc(KHALT, 0);
      run_prog(60, h);
      // random programs; ones that never halt are cut off by a reset
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 1024; i++) rom[i] = 9'($urandom);
         run_prog(40, h);
         if (!h) do_reset();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RESET_N  in  1  asynchronous, active-low reset.
REQ-003 START  in  1  level; sampled in IDLE/DONE, begins program at PC 0.
REQ-004 ACK  out  1  high in DONE (program reached KHALT).
REQ-005 IMEM_ADDR  out  10  instruction address (PC); synchronous instruction ROM, 1-cycle read latency.
REQ-006 IMEM_DATA  in  9  instruction word: [8:5] opcode, [4:0] operand field.
REQ-007 ALU_OP  out  4  opcode to ALU OP port.
REQ-008 ALU_A, ALU_B  out  8 each  ALU INPUTA/INPUTB.
REQ-009 ALU_IS_BRANCH  out  1  ALU IS_BRANCH.
REQ-010 ALU_OUT  in  8  ALU result (combinational).
REQ-011 ALU_BRANCH  in  1  ALU branch flag.
REQ-012 DMEM_ADDR  out  8, DMEM_WDATA  out  8, DMEM_WE  out  1, DMEM_RDATA  in  8: synchronous data RAM, 1-cycle read latency.

Function
REQ-013 Internal register file: R0..R7, 8 bits each; R0 is the accumulator; rs = operand[2:0].
REQ-014 States: IDLE, FETCH, DECODE, EXEC, MEM, DONE.
REQ-015 IDLE/DONE: START=1 -> PC<=0, ACK<=0, FETCH next; otherwise hold.
REQ-016 FETCH: IMEM_ADDR=PC -> DECODE.
REQ-017 DECODE: latch IMEM_DATA into IR -> EXEC.
REQ-018 EXEC: drive ALU_OP=IR[8:5], ALU_A/ALU_B per REQ-019..023, sample ALU outputs same cycle; next state MEM for KLOA, DONE for KHALT, else FETCH.
REQ-019 KADD/KSUB/KAND/kor/KXOR/KLSH/KRSH: A=R0, B=R[rs]; R0<=ALU_OUT; PC+1.
REQ-020 KGET: B=R[rs], R0<=ALU_OUT; KSET: A=R0, R[rs]<=ALU_OUT; KGETI: B=zero-extended operand[4:0], R0<=ALU_OUT.
REQ-021 KSTR: B=R0, DMEM_ADDR=R[rs], DMEM_WDATA=ALU_OUT, DMEM_WE=1 for exactly the EXEC cycle.
REQ-022 KLOA: A=R[rs], DMEM_ADDR=ALU_OUT in EXEC; MEM cycle: R0<=DMEM_RDATA, PC+1, -> FETCH.
REQ-023 KBRN: A=R0, ALU_IS_BRANCH=1; ALU_BRANCH=1 -> PC<=PC+sign-extended operand[4:0], else PC+1.
REQ-024 KHALT: PC unchanged, ACK<=1 entering DONE.
REQ-025 lookup and unassigned codes: NOP, PC+1, no register/memory write.
REQ-026 Latency: 3 cycles per instruction, 4 for KLOA.
REQ-027 PC arithmetic modulo 1024 (1023+1=0; branch wraps both directions).
REQ-028 ALU_OP/ALU_A/ALU_B/ALU_IS_BRANCH/DMEM_WE are 0 outside EXEC; DMEM_ADDR also held in MEM.
REQ-029 START outside IDLE/DONE ignored.

Reset
REQ-030 RESET_N=0 asynchronously: state IDLE, PC 0, IR 0, R0..R7 0, ACK 0, DMEM_WE 0, all outputs 0.
REQ-031 Reset mid-instruction aborts it; no register or memory write completes.

Structure
REQ-032 Opcode encodings from shared package definitions (op_mne); KBRN and KHALT added there on two unused codes; state enum seq_state_t and PC_W=10 also there.
REQ-033 One sub-module: seq_regfile (8x8, two async read ports, one sync write port, async reset).

Verification
REQ-034 Reset then START=1: fetch at PC 0 on cycle 1; KGETI 5 -> R0=5 three cycles later.
REQ-035 R0=5, R1=3 (via KGETI/KSET), KSUB r1 -> R0=2, ZERO unaffected; KADD r1 -> R0=5.
REQ-036 R2=0x10, R0=0xAB, KSTR r2 -> DMEM_WE high one cycle, addr 0x10, data 0xAB; KGETI 0, KLOA r2 -> R0=0xAB after 4 cycles.
REQ-037 R0=1, KBRN -2 at PC 4 -> next fetch PC 2; R0=0 -> PC 5; KBRN -1 at PC 0 -> PC 1023.
REQ-038 KHALT -> ACK=1, PC frozen; START again -> ACK=0, fetch PC 0.
REQ-039 RESET_N low during EXEC of KSTR -> DMEM_WE drops immediately, state IDLE, all registers 0.
